// File: rtl/pc_gen.sv
// Fetch program-counter generator: holds the fetch PC, offers it through a
// valid/ready handshake and picks the next PC from trap, flush, branch or increment.
module pc_gen #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
   parameter int              IALIGN   = 32,
   parameter int              INC      = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            flush_valid,
   input  logic [XLEN-1:0] flush_pc,
   input  logic            br_valid,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_offset,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic            misalign_err,
   output logic [XLEN-1:0] misalign_addr
);

   localparam int ALIGN_BITS = (IALIGN == 16) ? 1 : 2;

   logic [XLEN-1:0] align_mask;
   logic [XLEN-1:0] if_pc_reg, if_pc_next;
   logic            if_valid_reg, if_valid_next;
   logic            misalign_err_reg, misalign_err_next;
   logic [XLEN-1:0] misalign_addr_reg, misalign_addr_next;
   logic [XLEN-1:0] redirect_target;
   logic            redirect_checked;
   logic            handshake;

   // Set bits mark the low address bits that must be zero in a legal target.
   genvar gi;
   generate
      for (gi = 0; gi < XLEN; gi++) begin : g_mask
         assign align_mask[gi] = (gi < ALIGN_BITS) ? 1'b1 : 1'b0;
      end
   endgenerate

   assign handshake = if_valid_reg & if_ready & ~halt;

   always_comb begin
      if_pc_next         = if_pc_reg;
      if_valid_next      = ~halt;
      misalign_err_next  = 1'b0;
      misalign_addr_next = misalign_addr_reg;
      redirect_target    = '0;
      redirect_checked   = 1'b0;

      if (flush_valid) begin
         redirect_target  = flush_pc;
         redirect_checked = 1'b1;
      end else if (br_valid && br_taken) begin
         redirect_target  = if_pc_reg + br_offset;
         redirect_checked = 1'b1;
      end

      // The trap outranks everything and its target is silently aligned.
      if (trap_valid) begin
         if_pc_next = trap_pc & ~align_mask;
      end else if (redirect_checked) begin
         if ((redirect_target & align_mask) != '0) begin
            if_pc_next         = TRAP_VEC;
            misalign_err_next  = 1'b1;
            misalign_addr_next = redirect_target;
         end else begin
            if_pc_next = redirect_target;
         end
      end else if (handshake) begin
         if_pc_next = if_pc_reg + XLEN'(INC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_pc_reg         <= RESET_PC;
         if_valid_reg      <= 1'b0;
         misalign_err_reg  <= 1'b0;
         misalign_addr_reg <= '0;
      end else begin
         if_pc_reg         <= if_pc_next;
         if_valid_reg      <= if_valid_next;
         misalign_err_reg  <= misalign_err_next;
         misalign_addr_reg <= misalign_addr_next;
      end
   end

   assign if_pc         = if_pc_reg;
   assign if_valid      = if_valid_reg;
   assign misalign_err  = misalign_err_reg;
   assign misalign_addr = misalign_addr_reg;

endmodule
